// File: rtl/lcd_spi_monitor_if.sv
// -----------------------------------------------------------------------------
// lcd_spi_monitor_if
//   4-wire ST7735 LCD SPI bus bundle (mode 0, MSB first).
//   Signals:
//     spi_cs   - chip select, active-low
//     spi_dc   - 0 = command, 1 = data
//     spi_sclk - bus clock
//     spi_mosi - bus data
//   Modports:
//     master - the write engine (drives the bus)
//     slave  - a passive receiver such as lcd_spi_monitor
// -----------------------------------------------------------------------------
interface lcd_spi_monitor_if;
  logic spi_cs;
  logic spi_dc;
  logic spi_sclk;
  logic spi_mosi;

  modport master (
    output spi_cs,
    output spi_dc,
    output spi_sclk,
    output spi_mosi
  );

  modport slave (
    input spi_cs,
    input spi_dc,
    input spi_sclk,
    input spi_mosi
  );
endinterface

// File: rtl/lcd_spi_monitor.sv
// -----------------------------------------------------------------------------
// lcd_spi_monitor
//   Passive receiver for the ST7735 LCD write bus. Rebuilds each transferred
//   byte into the {dc, byte} word format used by the write engine and, when
//   built with LCD_SPI_MONITOR_PIXEL_DECODE_EN defined, decodes CASET / RASET /
//   RAMWR into addressed RGB565 pixel strobes. Without the macro the pixel
//   outputs are tied to zero; cmd_code is tracked in both builds.
//
//   Parameters:
//     SYNC_STAGES - flops per input synchroniser (>= 2)
//     X_MAX       - reset value of the window column end
//     Y_MAX       - reset value of the window row end
//   Ports:
//     sys_clk, sys_rst_n  - single clock, asynchronous active-low reset
//     spi (slave)         - monitored LCD bus (cs, dc, sclk, mosi)
//     rx_data / rx_valid  - {dc, byte} of the last complete byte + strobe
//     frame_err           - strobe: CS rose with a partial byte pending
//     cmd_code            - last command byte seen
//     pix_data/x/y/valid  - decoded RGB565 pixel + address + strobe
//     win_done            - strobe with the pixel that finishes the window
// -----------------------------------------------------------------------------
module lcd_spi_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int X_MAX       = 127,
  parameter int Y_MAX       = 159
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  lcd_spi_monitor_if.slave    spi,
  output logic [8:0]          rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic [7:0]          cmd_code,
  output logic [15:0]         pix_data,
  output logic [7:0]          pix_x,
  output logic [7:0]          pix_y,
  output logic                pix_valid,
  output logic                win_done
);

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // ---------------------------------------------------------------------------
  // Input synchronisers: identical depth on all four lines keeps them aligned.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_sync   <= '0;
      dc_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi.spi_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0],   spi.spi_dc};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detect plus one alignment register on every line. The extra stage
  // places rx_valid SYNC_STAGES+1 cycles after the sampling edge and keeps
  // cs/dc/mosi in step with the registered rise.
  // ---------------------------------------------------------------------------
  logic sclk_prev;
  logic rise_q;
  logic cs_q;
  logic dc_q;
  logic mosi_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_prev <= 1'b0;
      rise_q    <= 1'b0;
      cs_q      <= 1'b0;
      dc_q      <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      rise_q    <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
      cs_q      <= cs_sync[SYNC_STAGES-1];
      dc_q      <= dc_sync[SYNC_STAGES-1];
      mosi_q    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Deserialiser
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       bit_take;
  logic       byte_done;
  logic [7:0] new_byte;

  // A rise coinciding with CS release is still taken when it is the 8th bit,
  // so the byte completes instead of being reported as a framing error.
  assign bit_take  = rise_q & (~cs_q | (bit_cnt == 3'd7));
  assign byte_done = rise_q & (bit_cnt == 3'd7);
  assign new_byte  = {shift_reg[6:0], mosi_q};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (bit_take) begin
        shift_reg <= new_byte;
        bit_cnt   <= bit_cnt + 3'd1;
        if (byte_done) begin
          rx_data  <= {dc_q, new_byte};
          rx_valid <= 1'b1;
        end
      end else if (cs_q) begin
        if (bit_cnt != 3'd0) begin
          frame_err <= 1'b1;
        end
        bit_cnt <= '0;
      end
    end
  end

  // Command tracking is present in every build.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_code <= '0;
    end else if (byte_done && !dc_q) begin
      cmd_code <= new_byte;
    end
  end

`ifdef LCD_SPI_MONITOR_PIXEL_DECODE_EN
  // ---------------------------------------------------------------------------
  // Window / pixel decoder
  // ---------------------------------------------------------------------------
  typedef enum logic {
    PIX_HI,
    PIX_LO
  } pix_state_t;

  pix_state_t pix_state;
  pix_state_t pix_state_nx;

  logic [7:0] xs;
  logic [7:0] xe;
  logic [7:0] ys;
  logic [7:0] ye;
  logic [7:0] cur_x;
  logic [7:0] cur_y;
  logic [7:0] hi_byte;
  logic [1:0] param_idx;
  logic       param_full;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_state <= PIX_HI;
    end else begin
      pix_state <= pix_state_nx;
    end
  end

  // Any command word drops a pending half-pixel; RAMWR data alternates bytes.
  always_comb begin
    pix_state_nx = pix_state;
    if (byte_done) begin
      if (!dc_q) begin
        pix_state_nx = PIX_HI;
      end else if (cmd_code == CMD_RAMWR) begin
        pix_state_nx = (pix_state == PIX_HI) ? PIX_LO : PIX_HI;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      xs         <= '0;
      xe         <= 8'(X_MAX);
      ys         <= '0;
      ye         <= 8'(Y_MAX);
      cur_x      <= '0;
      cur_y      <= '0;
      hi_byte    <= '0;
      param_idx  <= '0;
      param_full <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_valid  <= 1'b0;
      win_done   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      win_done  <= 1'b0;
      if (byte_done) begin
        if (!dc_q) begin
          param_idx  <= '0;
          param_full <= 1'b0;
          if (new_byte == CMD_RAMWR) begin
            cur_x <= xs;
            cur_y <= ys;
          end
        end else begin
          // Index stops at 3; the full flag makes a 5th+ parameter a no-op.
          if (!param_full) begin
            if (param_idx == 2'd3) begin
              param_full <= 1'b1;
            end else begin
              param_idx <= param_idx + 2'd1;
            end
          end
          case (cmd_code)
            CMD_CASET: begin
              if (!param_full && param_idx == 2'd1) xs <= new_byte;
              if (!param_full && param_idx == 2'd3) xe <= new_byte;
            end
            CMD_RASET: begin
              if (!param_full && param_idx == 2'd1) ys <= new_byte;
              if (!param_full && param_idx == 2'd3) ye <= new_byte;
            end
            CMD_RAMWR: begin
              if (pix_state == PIX_HI) begin
                hi_byte <= new_byte;
              end else begin
                pix_data  <= {hi_byte, new_byte};
                pix_x     <= cur_x;
                pix_y     <= cur_y;
                pix_valid <= 1'b1;
                if (cur_x >= xe) begin
                  cur_x <= xs;
                  if (cur_y >= ye) begin
                    cur_y    <= ys;
                    win_done <= 1'b1;
                  end else begin
                    cur_y <= cur_y + 8'd1;
                  end
                end else begin
                  cur_x <= cur_x + 8'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
`else
  assign pix_data  = '0;
  assign pix_x     = '0;
  assign pix_y     = '0;
  assign pix_valid = 1'b0;
  assign win_done  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// -----------------------------------------------------------------------------
// tb_lcd_spi_monitor
//   Directed bench for lcd_spi_monitor (SYNC_STAGES = 2). Drives the LCD bus
//   at sys_clk/4 and checks received words, strobe latency, framing errors,
//   window decoding and reset behaviour. Pixel expectations follow
//   LCD_SPI_MONITOR_PIXEL_DECODE_EN.
// -----------------------------------------------------------------------------
module tb_lcd_spi_monitor;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [8:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [7:0]  cmd_code;
  logic [15:0] pix_data;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_valid;
  logic        win_done;

  always #5 sys_clk = ~sys_clk;

  lcd_spi_monitor_if bus();

  lcd_spi_monitor #(
    .SYNC_STAGES (2),
    .X_MAX       (127),
    .Y_MAX       (159)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi       (bus),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .cmd_code  (cmd_code),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .win_done  (win_done)
  );

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int unsigned exp_lsb = 0;
  int unsigned exp_cs = 0;
  int fe_total = 0;
  int nz_cnt = 0;

  typedef struct {
    logic [8:0]  d;
    int unsigned c;
  } rx_ev_t;

  rx_ev_t      rx_q[$];
  int unsigned fe_q[$];
  logic [33:0] pix_q[$];

  // Event recorder, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (rx_valid) rx_q.push_back('{rx_data, cyc});
    if (frame_err) begin
      fe_q.push_back(cyc);
      fe_total++;
    end
    if (pix_valid) pix_q.push_back({pix_data, pix_x, pix_y, win_done, rx_valid});
    if (pix_valid || win_done || pix_data != 16'h0 || pix_x != 8'h0 || pix_y != 8'h0)
      nz_cnt++;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends the first n bits of b; cs_last releases CS together with the last rise.
  task automatic drive_bits(input logic dc, input logic [7:0] b,
                            input int unsigned n, input bit cs_last);
    bus.spi_cs = 1'b0;
    bus.spi_dc = dc;
    tick(2);
    for (int unsigned i = 0; i < n; i++) begin
      bus.spi_mosi = b[7-i];
      tick(2);
      bus.spi_sclk = 1'b1;
      if (i == 7) exp_lsb = cyc + 4;
      if (cs_last && i == n - 1) bus.spi_cs = 1'b1;
      tick(2);
      bus.spi_sclk = 1'b0;
    end
    tick(2);
    if (bus.spi_cs == 1'b0) exp_cs = cyc + 4;
    bus.spi_cs = 1'b1;
    tick(3);
  endtask

  task automatic check_rx(input string name, input logic [8:0] exp);
    rx_ev_t ev;
    if (rx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no rx_valid seen, expected rx_data 0x%0h", name, exp);
    end else begin
      ev = rx_q.pop_front();
      chk({name, " data"}, 64'(ev.d), 64'(exp));
      chk({name, " latency"}, 64'(ev.c), 64'(exp_lsb));
    end
  endtask

  task automatic send_word(input logic [8:0] w);
    drive_bits(w[8], w[7:0], 8, 1'b0);
    check_rx("rx_word", w);
  endtask

  task automatic check_pix(input string name, input logic [33:0] exp);
    if (pix_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no pix_valid seen, expected 0x%0h", name, exp);
    end else begin
      chk(name, 64'(pix_q.pop_front()), 64'(exp));
    end
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] b;
    logic [8:0] rx;
    logic [7:0] cmd;
  } vec_t;

  vec_t        vecs[6];
  logic [8:0]  win_seq[19];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 8'h36, 9'h036, 8'h36};
    vecs[1] = '{1'b1, 8'hC8, 9'h1C8, 8'h36};
    vecs[2] = '{1'b0, 8'hFF, 9'h0FF, 8'hFF};
    vecs[3] = '{1'b1, 8'h00, 9'h100, 8'hFF};
    vecs[4] = '{1'b1, 8'hA5, 9'h1A5, 8'hFF};
    vecs[5] = '{1'b0, 8'h01, 9'h001, 8'h01};

    win_seq = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h103,
                9'h02B, 9'h100, 9'h105, 9'h100, 9'h106,
                9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100,
                9'h1F8, 9'h100, 9'h1F8, 9'h100};

    bus.spi_cs   = 1'b1;
    bus.spi_dc   = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;

    // Reset state
    tick(3);
    chk("reset rx_data", 64'(rx_data), 64'h0);
    chk("reset strobes", 64'({rx_valid, frame_err, pix_valid, win_done}), 64'h0);
    chk("reset cmd_code", 64'(cmd_code), 64'h0);
    chk("reset pix", 64'({pix_data, pix_x, pix_y}), 64'h0);
    sys_rst_n = 1'b1;
    tick(5);
    chk("no strobe on release", 64'(rx_q.size() + fe_q.size() + pix_q.size()), 64'h0);

    // Basic words, latency and command tracking
    for (int unsigned i = 0; i < 6; i++) begin
      drive_bits(vecs[i].dc, vecs[i].b, 8, 1'b0);
      check_rx("vec", vecs[i].rx);
      chk("vec cmd_code", 64'(cmd_code), 64'(vecs[i].cmd));
    end

    // CS released after 5 bits: one frame_err, partial byte discarded
    drive_bits(1'b1, 8'hA5, 5, 1'b0);
    tick(4);
    chk("frame_err count", 64'(fe_q.size()), 64'h1);
    if (fe_q.size() != 0) chk("frame_err latency", 64'(fe_q.pop_front()), 64'(exp_cs));
    chk("partial byte no rx", 64'(rx_q.size()), 64'h0);
    send_word(9'h13C);

    // CS released with the 8th rise: byte completes, no frame_err
    drive_bits(1'b1, 8'h5A, 8, 1'b1);
    tick(4);
    check_rx("cs coincident", 9'h15A);
    chk("cs coincident no frame_err", 64'(fe_q.size()), 64'h0);

    // Window 2..3 x 5..6, four red pixels
    foreach (win_seq[i]) send_word(win_seq[i]);
`ifdef LCD_SPI_MONITOR_PIXEL_DECODE_EN
    check_pix("pix (2,5)", {16'hF800, 8'd2, 8'd5, 1'b0, 1'b1});
    check_pix("pix (3,5)", {16'hF800, 8'd3, 8'd5, 1'b0, 1'b1});
    check_pix("pix (2,6)", {16'hF800, 8'd2, 8'd6, 1'b0, 1'b1});
    check_pix("pix (3,6) win_done", {16'hF800, 8'd3, 8'd6, 1'b1, 1'b1});
`endif
    chk("pix extra", 64'(pix_q.size()), 64'h0);

    // Dangling byte dropped by a command; RAMWR restarts at the window origin
    send_word(9'h02C);
    send_word(9'h1F8);
    send_word(9'h100);
    send_word(9'h112);
    send_word(9'h000);
`ifdef LCD_SPI_MONITOR_PIXEL_DECODE_EN
    check_pix("dangling single pix", {16'hF800, 8'd2, 8'd5, 1'b0, 1'b1});
`endif
    chk("dangling pix count", 64'(pix_q.size()), 64'h0);
    send_word(9'h02C);
    send_word(9'h1AB);
    send_word(9'h1CD);
`ifdef LCD_SPI_MONITOR_PIXEL_DECODE_EN
    check_pix("restart pix", {16'hABCD, 8'd2, 8'd5, 1'b0, 1'b1});
`endif

    // Reset mid-byte during RAMWR
    send_word(9'h02C);
    bus.spi_cs = 1'b0;
    bus.spi_dc = 1'b1;
    tick(2);
    for (int unsigned i = 0; i < 4; i++) begin
      bus.spi_mosi = i[0];
      tick(2);
      bus.spi_sclk = 1'b1;
      tick(2);
      bus.spi_sclk = 1'b0;
    end
    sys_rst_n = 1'b0;
    #1;
    chk("midreset rx_data", 64'(rx_data), 64'h0);
    chk("midreset cmd_code", 64'(cmd_code), 64'h0);
    chk("midreset pix", 64'({pix_data, pix_x, pix_y}), 64'h0);
    chk("midreset strobes", 64'({rx_valid, frame_err, pix_valid, win_done}), 64'h0);
    bus.spi_cs   = 1'b1;
    bus.spi_sclk = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(6);
    chk("post-reset quiet", 64'(rx_q.size() + fe_q.size() + pix_q.size()), 64'h0);

    // Default window after reset
    send_word(9'h02C);
    send_word(9'h112);
    send_word(9'h134);
    send_word(9'h156);
    send_word(9'h178);
`ifdef LCD_SPI_MONITOR_PIXEL_DECODE_EN
    check_pix("default pix (0,0)", {16'h1234, 8'd0, 8'd0, 1'b0, 1'b1});
    check_pix("default pix (1,0)", {16'h5678, 8'd1, 8'd0, 1'b0, 1'b1});
`else
    chk("pixel outputs stay zero", 64'(nz_cnt), 64'h0);
`endif

    tick(10);
    chk("total frame_err", 64'(fe_total), 64'h1);
    chk("no stray rx", 64'(rx_q.size()), 64'h0);
    chk("no stray pix", 64'(pix_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_spi_monitor.md
# lcd_spi_monitor

Receive-side counterpart of the ST7735 SPI write path: passively samples the 4-wire LCD bus (CS, DC, SCLK, MOSI) produced by the LCD write engine. Deserialises each transfer back into the same 9-bit {dc, byte} word format the write engine consumes. Optionally decodes CASET/RASET/RAMWR into addressed RGB565 pixel strobes. Used on-chip for self-check of the init and char-display paths, and as a bench/ILA probe point.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser (≥2)
- X_MAX, 127, reset value of window column end
- Y_MAX, 159, reset value of window row end

Ports:
- sys_clk  in  1  system clock; the single clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- spi_cs  in  1  bus chip select, active-low
- spi_dc  in  1  0 = command, 1 = data
- spi_sclk  in  1  bus clock, mode 0, MSB first
- spi_mosi  in  1  bus data
- rx_data  out  9  {dc, byte} of last complete byte
- rx_valid  out  1  one-cycle strobe, rx_data new
- frame_err  out  1  one-cycle strobe, CS rose mid-byte
- cmd_code  out  8  last command byte received
- pix_data  out  16  RGB565 pixel
- pix_x  out  8  pixel column
- pix_y  out  8  pixel row
- pix_valid  out  1  one-cycle strobe, pix_* new
- win_done  out  1  one-cycle strobe, last pixel of window written

## Operation
- All four bus inputs pass through identical SYNC_STAGES synchronisers, keeping them mutually aligned.
- An SCLK rising edge is detected when the last sync stage is 1 and the previous stage value was 0.
- Bit capture happens only while synced CS = 0. On each detected rise, MOSI shifts into an 8-bit register (MSB first) and the 3-bit counter increments.
- On the 8th bit:
  - rx_data = {synced DC, byte}.
  - rx_valid pulses.
  - The counter wraps to 0.
- Synced CS = 1 clears the counter. If the counter was nonzero when CS rose, frame_err pulses and the partial byte is discarded.
- Decoder state persists across CS deassertion, because the write engine may toggle CS per byte.
- Command word (dc = 0): cmd_code updated, parameter index cleared, any pending half-pixel dropped.
- Data word (dc = 1), decoded per cmd_code:
  - 0x2A CASET: parameter index 1 → xs, index 3 → xe. Indices 0 and 2 (high bytes) are ignored.
  - 0x2B RASET: same scheme into ys and ye.
  - 0x2C RAMWR: the first byte is latched as the high byte; the second byte completes pix_data.
    - pix_valid pulses with pix_x/pix_y = current (x, y).
    - Then advance: if x ≥ xe, x ← xs and row-advance; else x ← x+1.
    - Row-advance: if y ≥ ye, y ← ys and win_done pulses together with pix_valid; else y ← y+1.
  - On receipt of the 0x2C command word: x ← xs, y ← ys.
  - Any other command: data passes on rx_data only; no decode effect.
- Parameter index saturates at 3. Parameters after the fourth are ignored.
- Reset values:
  - Outputs: rx_data 0, rx_valid 0, frame_err 0, cmd_code 0x00, pix_data 0, pix_x 0, pix_y 0, pix_valid 0, win_done 0.
  - Internal: xs 0, xe X_MAX, ys 0, ye Y_MAX.
- Reset asserted mid-byte or mid-pixel: all state is cleared immediately. No strobes fire on reset release.

## Timing
- Each SCLK high and low phase must last ≥2 sys_clk cycles. The write engine with HALFBASE = 0 (SCLK = sys_clk/4) meets this.
- rx_valid is registered. It is high exactly SYNC_STAGES+1 cycles after the first sys_clk edge that samples spi_sclk = 1 for bit 0 (LSB).
- pix_valid/win_done assert in the same cycle as the rx_valid of the completing low byte.
- frame_err asserts SYNC_STAGES+1 cycles after CS is first sampled high.
- All strobes last 1 cycle. rx_data, cmd_code and pix_* hold until next update.
- CS rising in the same cycle as the 8th SCLK rise: the byte completes (rx_valid), the counter is then cleared, and there is no frame_err.

## Configuration
- LCD_SPI_MONITOR_PIXEL_DECODE_EN defined: CASET/RASET/RAMWR decoder built as above.
- Undefined: the decoder is omitted.
  - pix_data, pix_x, pix_y, pix_valid and win_done are tied 0.
  - cmd_code is still updated.
  - rx_data/rx_valid/frame_err are unchanged.

## Test plan
- Send command 0x36 then data 0xC8 → rx_data 0x036 then 0x1C8. Each rx_valid is one cycle at SYNC_STAGES+1 latency; cmd_code = 0x36.
- Raise CS after 5 bits of 0xA5, then send 0x3C → frame_err pulses once, no rx_valid for the partial byte; next rx_data = 0x13C (dc = 1).
- CASET 00 02 00 03, RASET 00 05 00 06, RAMWR, then 8 data bytes 0xF8 0x00 ×4 → four pix_valid with (x, y) = (2,5), (3,5), (2,6), (3,6), all pix_data = 0xF800; win_done coincides with the 4th only.
- With window still 2..3 × 5..6, RAMWR, 3 bytes, then command 0x00 → one pix_valid only; the dangling byte is dropped. A following RAMWR restarts at (2,5).
- Assert sys_rst_n low mid-byte during RAMWR → all outputs 0 within the reset cycle. After release, a RAMWR plus 2 bytes gives pixel (0,0) with window 0..127 × 0..159.
- Build without the macro and run the pixel scenario → rx_data sequence identical, all pix_*/win_done stay 0.
